// File: rtl/pixel_scheduler_if.sv
// Handshake bundle between the pixel scheduler and its frame controller / engine array.
interface pixel_scheduler_if #(
    parameter int NUM_ENGINES      = 8,
    parameter int PIXEL_DATA_WIDTH = 10
);
    logic                        start;
    logic                        abort;
    logic                        continuous;
    logic [NUM_ENGINES-1:0]      engine_ready;
    logic [NUM_ENGINES-1:0]      engine_done;
    logic [NUM_ENGINES-1:0]      grant_o;
    logic [PIXEL_DATA_WIDTH-1:0] x_o;
    logic [PIXEL_DATA_WIDTH-1:0] y_o;
    logic                        busy;
    logic                        frame_done;
    logic [15:0]                 frame_count;

    modport master (
        output start, abort, continuous, engine_ready, engine_done,
        input  grant_o, x_o, y_o, busy, frame_done, frame_count
    );

    modport slave (
        input  start, abort, continuous, engine_ready, engine_done,
        output grant_o, x_o, y_o, busy, frame_done, frame_count
    );
endinterface

// File: rtl/pixel_scheduler.sv
// Hands out frame pixels in raster order to a pool of mandelbrot engines (round-robin)
// and tracks in-flight pixels so a frame is reported complete only once all results land.
//
// state    | meaning
// IDLE     | waiting for start, no grants
// DISPATCH | granting pixels, one per cycle to an eligible engine
// DRAIN    | all pixels issued (or aborted), waiting for outstanding work to finish
module pixel_scheduler #(
    parameter int NUM_ENGINES      = 8,
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int X_SIZE           = 640,
    parameter int Y_SIZE           = 480
) (
    input logic              clk,
    input logic              reset,
    pixel_scheduler_if.slave sif
);
    localparam int NPIX = X_SIZE * Y_SIZE;
    localparam int OW   = $clog2(NPIX + 1);
    localparam int EW   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(X_SIZE - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(Y_SIZE - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [PIXEL_DATA_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [PIXEL_DATA_WIDTH-1:0] xo_q, xo_d, yo_q, yo_d;
    logic [EW-1:0]               last_q, last_d;
    logic [OW-1:0]               out_q, out_d;
    logic                        abort_q, abort_d;
    logic [NUM_ENGINES-1:0]      grant_q, grant_d;
    logic                        fdone_q, fdone_d;
    logic [15:0]                 fcnt_q, fcnt_d;
    logic                        busy_q;

    logic [NUM_ENGINES-1:0]      eligible;
    logic                        pick_valid;
    logic [EW-1:0]               pick_idx;
    logic [EW-1:0]               cand;
    logic                        grant_now;
    int                          out_sum;
    int                          done_cnt;

    // An engine granted last cycle may still show ready, so it is masked for one cycle.
    always_comb begin
        eligible   = sif.engine_ready & ~grant_q;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_ENGINES; k++) begin
            cand = EW'((int'(last_q) + k) % NUM_ENGINES);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign grant_now = (state_q == DISPATCH) && !sif.abort && pick_valid;

    // Stray done pulses can never drive the count below zero.
    always_comb begin
        out_sum  = int'(out_q) + (grant_now ? 1 : 0);
        done_cnt = $countones(sif.engine_done);
        if (done_cnt > out_sum) begin
            out_d = '0;
        end else begin
            out_d = OW'(out_sum - done_cnt);
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        last_d  = last_q;
        abort_d = abort_q;
        grant_d = '0;
        fdone_d = 1'b0;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (sif.start) begin
                    state_d = DISPATCH;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            DISPATCH: begin
                if (sif.abort) begin
                    state_d = DRAIN;
                    abort_d = 1'b1;
                end else if (grant_now) begin
                    grant_d[pick_idx] = 1'b1;
                    xo_d              = x_q;
                    yo_d              = y_q;
                    last_d            = pick_idx;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_d == '0) begin
                    x_d = '0;
                    y_d = '0;
                    if (abort_q) begin
                        state_d = IDLE;
                        abort_d = 1'b0;
                    end else begin
                        fdone_d = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                        state_d = sif.continuous ? DISPATCH : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            last_q  <= EW'(NUM_ENGINES - 1);
            out_q   <= '0;
            abort_q <= 1'b0;
            grant_q <= '0;
            fdone_q <= 1'b0;
            fcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            last_q  <= last_d;
            out_q   <= out_d;
            abort_q <= abort_d;
            grant_q <= grant_d;
            fdone_q <= fdone_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign sif.grant_o     = grant_q;
    assign sif.x_o         = xo_q;
    assign sif.y_o         = yo_q;
    assign sif.busy        = busy_q;
    assign sif.frame_done  = fdone_q;
    assign sif.frame_count = fcnt_q;
endmodule

// File: tb/tb_pixel_scheduler.sv
// Randomized bench for pixel_scheduler: engine models plus a frame-level reference model
// feed expected grants / frame completions into queues that a separate monitor drains.
module tb_pixel_scheduler;
    localparam int NE   = 8;
    localparam int PW   = 10;
    localparam int XS   = 4;
    localparam int YS   = 2;
    localparam int NPIX = XS * YS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_scheduler_if #(.NUM_ENGINES(NE), .PIXEL_DATA_WIDTH(PW)) sif ();

    pixel_scheduler #(
        .NUM_ENGINES(NE), .PIXEL_DATA_WIDTH(PW), .X_SIZE(XS), .Y_SIZE(YS)
    ) dut (
        .clk(clk),
        .reset(rst),
        .sif(sif)
    );

    typedef struct {int tag; int eng; int x; int y;} gexp_t;
    typedef struct {int tag; int fc;} fexp_t;
    gexp_t gq[$];
    fexp_t fq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // engine models and stimulus knobs
    bit          busy_e [NE];
    int          cnt_e  [NE];
    bit          start_r, abort_r, cont_r;
    int          ready_pct = 100;
    logic [NE-1:0] allow = '1;
    logic [NE-1:0] spur  = '0;

    // reference model: a frame is a list of pixels 0..NPIX-1 handed out in order
    int m_phase;   // 0 idle, 1 issuing pixels, 2 waiting for results
    int m_pix, m_out, m_last, m_prev, m_fc, m_fgr;
    bit m_abort;

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pix = 0; m_out = 0; m_last = NE - 1; m_prev = -1;
        m_fc = 0; m_fgr = 0; m_abort = 0;
        gq.delete();
        fq.delete();
        for (int i = 0; i < NE; i++) begin
            busy_e[i] = 0;
            cnt_e[i]  = 0;
        end
    endtask

    task automatic step();
        logic [NE-1:0] rdy, dn;
        int g, pc, old;
        gexp_t ge;
        fexp_t fe;
        @(negedge clk);
        dn = '0;
        rdy = '0;
        for (int i = 0; i < NE; i++) begin
            if (busy_e[i]) begin
                cnt_e[i]--;
                if (cnt_e[i] <= 0) begin
                    busy_e[i] = 0;
                    dn[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NE; i++) begin
            if (sif.grant_o[i]) begin
                busy_e[i] = 1;
                cnt_e[i]  = int'($urandom_range(1, 4));
            end
        end
        for (int i = 0; i < NE; i++)
            rdy[i] = !busy_e[i] && allow[i] && (int'($urandom_range(0, 99)) < ready_pct);
        dn = dn | spur;
        sif.start        = start_r;
        sif.abort        = abort_r;
        sif.continuous   = cont_r;
        sif.engine_ready = rdy;
        sif.engine_done  = dn;

        g = -1;
        pc = $countones(dn);
        old = m_phase;
        if (m_phase == 0) begin
            if (start_r) begin
                m_phase = 1; m_pix = 0; m_fgr = 0;
            end
        end else if (m_phase == 1) begin
            if (abort_r) begin
                m_phase = 2; m_abort = 1;
            end else begin
                for (int k = 1; k <= NE; k++) begin
                    int e;
                    e = (m_last + k) % NE;
                    if (g < 0 && rdy[e] && e != m_prev) g = e;
                end
                if (g >= 0) begin
                    ge.tag = cyc + 1; ge.eng = g; ge.x = m_pix % XS; ge.y = m_pix / XS;
                    gq.push_back(ge);
                    m_last = g;
                    m_pix++;
                    m_fgr++;
                    if (m_pix == NPIX) m_phase = 2;
                end
            end
        end
        m_out = m_out + ((g >= 0) ? 1 : 0) - pc;
        if (m_out < 0) m_out = 0;
        if (old == 2 && m_out == 0) begin
            if (m_abort) begin
                m_phase = 0; m_abort = 0;
            end else begin
                m_fc = (m_fc + 1) % 65536;
                fe.tag = cyc + 1; fe.fc = m_fc;
                fq.push_back(fe);
                if (cont_r) begin
                    m_phase = 1; m_pix = 0; m_fgr = 0;
                end else begin
                    m_phase = 0;
                end
            end
        end
        m_prev = g;
    endtask

    function automatic bit engines_busy();
        bit b = 0;
        for (int i = 0; i < NE; i++) b |= busy_e[i];
        return b;
    endfunction

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((m_phase != 0 || engines_busy()) && n < maxc) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= maxc) begin
            n_bad++;
            $display("FAIL idle_timeout: still active after %0d cycles, required idle", n);
        end
        step();
        step();
    endtask

    task automatic pulse_start();
        start_r = 1;
        step();
        start_r = 0;
    endtask

    // monitor: pops expectations whenever the DUT presents a grant or a frame_done
    gexp_t       mg;
    fexp_t       mf;
    int          hx = 0, hy = 0;
    logic [NE-1:0] eg;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            hx = 0;
            hy = 0;
        end else begin
            if (sif.grant_o != '0) begin
                n_cmp++;
                if (gq.size() == 0) begin
                    n_bad++;
                    $display("FAIL grant_unexpected: cyc %0d got grant %b, required none", cyc, sif.grant_o);
                end else begin
                    mg = gq.pop_front();
                    eg = '0;
                    eg[mg.eng] = 1'b1;
                    if (mg.tag != cyc || sif.grant_o != eg || int'(sif.x_o) != mg.x || int'(sif.y_o) != mg.y) begin
                        n_bad++;
                        $display("FAIL grant: cyc %0d grant %b (%0d,%0d); required cyc %0d grant %b (%0d,%0d)",
                                 cyc, sif.grant_o, sif.x_o, sif.y_o, mg.tag, eg, mg.x, mg.y);
                    end
                    hx = mg.x;
                    hy = mg.y;
                end
            end else begin
                if (gq.size() != 0 && gq[0].tag <= cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL grant_missed: cyc %0d got none, required engine %0d at cyc %0d", cyc, gq[0].eng, gq[0].tag);
                    gq.delete(0);
                end
                n_cmp++;
                if (int'(sif.x_o) != hx || int'(sif.y_o) != hy) begin
                    n_bad++;
                    $display("FAIL coord_hold: cyc %0d got (%0d,%0d) required (%0d,%0d)", cyc, sif.x_o, sif.y_o, hx, hy);
                end
            end
            if (sif.frame_done) begin
                n_cmp++;
                if (fq.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_done_unexpected: cyc %0d got pulse, required none", cyc);
                end else begin
                    mf = fq.pop_front();
                    if (mf.tag != cyc || int'(sif.frame_count) != mf.fc) begin
                        n_bad++;
                        $display("FAIL frame_done: cyc %0d count %0d; required cyc %0d count %0d", cyc, sif.frame_count, mf.tag, mf.fc);
                    end
                end
            end else if (fq.size() != 0 && fq[0].tag <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_done_missed: cyc %0d got none, required pulse at cyc %0d", cyc, fq[0].tag);
                fq.delete(0);
            end
        end
    end

    initial begin
        int base, n;
        start_r = 0; abort_r = 0; cont_r = 0;
        sif.start = 0; sif.abort = 0; sif.continuous = 0;
        sif.engine_ready = '0; sif.engine_done = '0;
        model_reset();
        #1 rst = 1;
        repeat (2) @(negedge clk);
        check("rst_grant", int'(sif.grant_o), 0);
        check("rst_x", int'(sif.x_o), 0);
        check("rst_y", int'(sif.y_o), 0);
        check("rst_busy", int'(sif.busy), 0);
        check("rst_frame_done", int'(sif.frame_done), 0);
        check("rst_frame_count", int'(sif.frame_count), 0);
        rst = 0;

        // all engines ready: engines 0,1,2.. in consecutive cycles, raster coordinates
        ready_pct = 100;
        pulse_start();
        step();
        check("busy_in_frame", int'(sif.busy), 1);
        wait_idle(200);
        check("busy_after_frame1", int'(sif.busy), 0);
        check("count_after_frame1", int'(sif.frame_count), 1);

        // stray done pulses while idle must not corrupt the outstanding count
        spur = '1;
        step();
        spur = '0;
        ready_pct = 60;
        pulse_start();
        wait_idle(300);
        check("count_after_frame2", int'(sif.frame_count), m_fc);

        // only engine 2 ever ready
        allow = 8'b0000_0100;
        ready_pct = 100;
        pulse_start();
        wait_idle(300);
        allow = '1;
        check("count_single_engine", int'(sif.frame_count), 3);

        // abort after five grants: no frame_done, count unchanged
        base = m_fc;
        pulse_start();
        n = 0;
        while (m_fgr < 5 && n < 100) begin
            step();
            n++;
        end
        check("abort_reached_5_grants", m_fgr, 5);
        abort_r = 1;
        step();
        abort_r = 0;
        wait_idle(200);
        check("count_after_abort", int'(sif.frame_count), base);
        check("busy_after_abort", int'(sif.busy), 0);

        // continuous: two back-to-back frames without an idle gap
        base = m_fc;
        cont_r = 1;
        pulse_start();
        n = 0;
        while (m_fc == base && n < 200) begin
            step();
            n++;
        end
        cont_r = 0;
        wait_idle(200);
        check("count_after_continuous", int'(sif.frame_count), base + 2);

        // random frames with random readiness, stray starts, occasional aborts and restarts
        for (int it = 0; it < 8; it++) begin
            ready_pct = int'($urandom_range(30, 100));
            pulse_start();
            n = 0;
            while ((m_phase != 0 || engines_busy()) && n < 400) begin
                start_r = ($urandom_range(0, 7) == 0);
                abort_r = (m_phase == 1) && ($urandom_range(0, 24) == 0);
                cont_r  = (n < 40) && ($urandom_range(0, 3) == 0);
                step();
                n++;
            end
            start_r = 0; abort_r = 0; cont_r = 0;
            wait_idle(400);
            check("count_random_iter", int'(sif.frame_count), m_fc);
        end

        // asynchronous reset in the middle of dispatch
        ready_pct = 50;
        pulse_start();
        repeat (3) step();
        #2 rst = 1;
        #1;
        check("async_rst_grant", int'(sif.grant_o), 0);
        check("async_rst_x", int'(sif.x_o), 0);
        check("async_rst_y", int'(sif.y_o), 0);
        check("async_rst_busy", int'(sif.busy), 0);
        check("async_rst_frame_done", int'(sif.frame_done), 0);
        check("async_rst_frame_count", int'(sif.frame_count), 0);
        sif.engine_ready = '0;
        sif.engine_done  = '0;
        sif.start = 0; sif.abort = 0; sif.continuous = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
        ready_pct = 100;
        pulse_start();
        wait_idle(200);
        check("count_after_reset_frame", int'(sif.frame_count), 1);

        check("grant_queue_empty", gq.size(), 0);
        check("frame_queue_empty", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
